// File: rtl/tdm_demux.sv
// Receive-side TDM deserializer: locks onto a frame-sync marker, steers each
// beat into its lane and presents a full parallel frame with a one-cycle pulse.
module tdm_demux #(
  parameter int WIDTH = 1,
  parameter int LANES = 2,
  parameter int SW    = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic                   sync,
  output logic [LANES*WIDTH-1:0] dout,
  output logic                   dout_valid,
  output logic [SW-1:0]          sel,
  output logic                   locked,
  output logic                   sync_err
);

  typedef enum logic {HUNT, RUN} state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          sel_q, sel_d;
  logic [LANES*WIDTH-1:0] shadow_q, shadow_d;
  logic [LANES*WIDTH-1:0] dout_q, dout_d;
  logic                   dv_q, dv_d;
  logic                   err_q, err_d;

  logic [LANES*WIDTH-1:0] slot_merged;
  logic [LANES*WIDTH-1:0] lane0_merged;
  logic                   last_slot;

  // Shadow content as it would look with the current beat written in place;
  // on the last slot this is exactly the frame handed to dout.
  always_comb begin
    slot_merged = shadow_q;
    slot_merged[int'(sel_q)*WIDTH +: WIDTH] = din;
    lane0_merged = shadow_q;
    lane0_merged[WIDTH-1:0] = din;
  end

  assign last_slot = (sel_q == SW'(LANES - 1));

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            state_d  = RUN;
            shadow_d = lane0_merged;
            sel_d    = SW'(1);
          end
        end
        RUN: begin
          if (sync && (sel_q != '0)) begin
            // Misaligned marker: drop the partial frame and restart at lane 0.
            err_d    = 1'b1;
            shadow_d = lane0_merged;
            sel_d    = SW'(1);
          end else begin
            shadow_d = slot_merged;
            if (last_slot) begin
              dout_d = slot_merged;
              dv_d   = 1'b1;
              sel_d  = '0;
            end else begin
              sel_d = sel_q + SW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      sel_q    <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign sel        = sel_q;
  assign locked     = (state_q == RUN);
  assign sync_err   = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: a 2x1-bit and a 4x8-bit instance checked every cycle
// against a frame-queue model, plus directed literal frame expectations.
module tb_tdm_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: LANES=2, WIDTH=1
  logic       va = 1'b0, sa = 1'b0;
  logic [0:0] da = '0;
  logic [1:0] dout_a;
  logic       dv_a, lock_a, err_a;
  logic [0:0] sel_a;

  // Instance B: LANES=4, WIDTH=8
  logic        vb = 1'b0, sb = 1'b0;
  logic [7:0]  db = '0;
  logic [31:0] dout_b;
  logic        dv_b, lock_b, err_b;
  logic [1:0]  sel_b;

  tdm_demux #(.WIDTH(1), .LANES(2)) dut_a (
    .clk(clk), .rst(rst), .din(da), .din_valid(va), .sync(sa),
    .dout(dout_a), .dout_valid(dv_a), .sel(sel_a), .locked(lock_a),
    .sync_err(err_a)
  );

  tdm_demux #(.WIDTH(8), .LANES(4)) dut_b (
    .clk(clk), .rst(rst), .din(db), .din_valid(vb), .sync(sb),
    .dout(dout_b), .dout_valid(dv_b), .sel(sel_b), .locked(lock_b),
    .sync_err(err_b)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is the list of beats collected since the last frame start.
  logic       qa[$];
  logic       ea_lock = 1'b0, ea_dv = 1'b0, ea_err = 1'b0;
  logic [1:0] ea_dout = '0;
  int         ea_sel  = 0;

  logic [7:0]  qb[$];
  logic        eb_lock = 1'b0, eb_dv = 1'b0, eb_err = 1'b0;
  logic [31:0] eb_dout = '0;
  int          eb_sel  = 0;

  always @(posedge clk) begin
    ea_dv  = 1'b0;
    ea_err = 1'b0;
    if (rst) begin
      qa.delete();
      ea_lock = 1'b0;
      ea_dout = '0;
    end else if (va) begin
      if (!ea_lock) begin
        if (sa) begin
          ea_lock = 1'b1;
          qa.push_back(da[0]);
        end
      end else begin
        if (sa && qa.size() != 0) begin
          ea_err = 1'b1;
          qa.delete();
        end
        qa.push_back(da[0]);
        if (qa.size() == 2) begin
          ea_dout = {qa[1], qa[0]};
          ea_dv   = 1'b1;
          qa.delete();
        end
      end
    end
    ea_sel = qa.size();
  end

  always @(posedge clk) begin
    eb_dv  = 1'b0;
    eb_err = 1'b0;
    if (rst) begin
      qb.delete();
      eb_lock = 1'b0;
      eb_dout = '0;
    end else if (vb) begin
      if (!eb_lock) begin
        if (sb) begin
          eb_lock = 1'b1;
          qb.push_back(db);
        end
      end else begin
        if (sb && qb.size() != 0) begin
          eb_err = 1'b1;
          qb.delete();
        end
        qb.push_back(db);
        if (qb.size() == 4) begin
          eb_dout = {qb[3], qb[2], qb[1], qb[0]};
          eb_dv   = 1'b1;
          qb.delete();
        end
      end
    end
    eb_sel = qb.size();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_dout",   32'(dout_a), 32'(ea_dout));
      chk("a_dvalid", 32'(dv_a),   32'(ea_dv));
      chk("a_sel",    32'(sel_a),  32'(ea_sel));
      chk("a_locked", 32'(lock_a), 32'(ea_lock));
      chk("a_syncerr",32'(err_a),  32'(ea_err));
      chk("b_dout",   dout_b,      eb_dout);
      chk("b_dvalid", 32'(dv_b),   32'(eb_dv));
      chk("b_sel",    32'(sel_b),  32'(eb_sel));
      chk("b_locked", 32'(lock_b), 32'(eb_lock));
      chk("b_syncerr",32'(err_b),  32'(eb_err));
    end
  end

  task automatic beat_a(input logic d, input logic s);
    @(negedge clk);
    va = 1'b1; da = d; sa = s;
  endtask

  task automatic beat_b(input logic [7:0] d, input logic s);
    @(negedge clk);
    vb = 1'b1; db = d; sb = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      va = 1'b0; sa = 1'b0; vb = 1'b0; sb = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; va = 1'b0; sa = 1'b0; vb = 1'b0; sb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    rst    = 1'b0;

    idle(5);
    chk("rst_dout_a", 32'(dout_a), 32'h0);
    chk("rst_sel_a",  32'(sel_a),  32'h0);
    chk("rst_lock_a", 32'(lock_a), 32'h0);
    chk("rst_dout_b", dout_b,      32'h0);
    chk("rst_lock_b", 32'(lock_b), 32'h0);

    // A: basic sync-started frame
    beat_a(1'b0, 1'b1);
    beat_a(1'b1, 1'b0);
    idle(1);
    chk("a_frame1_dout", 32'(dout_a), 32'h2);
    chk("a_frame1_dv",   32'(dv_a),   32'h1);
    chk("a_frame1_sel",  32'(sel_a),  32'h0);
    chk("a_frame1_lock", 32'(lock_a), 32'h1);
    idle(1);
    chk("a_frame1_pulse", 32'(dv_a),  32'h0);
    chk("a_frame1_hold",  32'(dout_a), 32'h2);

    // A: beats in HUNT are dropped until a sync arrives
    do_reset();
    beat_a(1'b1, 1'b0);
    beat_a(1'b1, 1'b0);
    beat_a(1'b0, 1'b0);
    idle(1);
    chk("a_hunt_sel",  32'(sel_a),  32'h0);
    chk("a_hunt_lock", 32'(lock_a), 32'h0);
    beat_a(1'b1, 1'b1);
    beat_a(1'b0, 1'b0);
    idle(1);
    chk("a_hunt_dout", 32'(dout_a), 32'h1);
    chk("a_hunt_dv",   32'(dv_a),   32'h1);

    // A: sync optional once locked; idle cycles hold sel
    beat_a(1'b1, 1'b0);
    idle(1);
    chk("a_idle_sel1", 32'(sel_a), 32'h1);
    idle(1);
    chk("a_idle_sel2", 32'(sel_a), 32'h1);
    chk("a_idle_dv",   32'(dv_a),  32'h0);
    beat_a(1'b1, 1'b0);
    idle(1);
    chk("a_nosync_dout", 32'(dout_a), 32'h3);
    chk("a_nosync_dv",   32'(dv_a),   32'h1);

    // B: full 4x8 frame
    beat_b(8'h11, 1'b1);
    beat_b(8'h22, 1'b0);
    beat_b(8'h33, 1'b0);
    beat_b(8'h44, 1'b0);
    idle(1);
    chk("b_frame_dout", dout_b,      32'h44332211);
    chk("b_frame_dv",   32'(dv_b),   32'h1);

    // B: misaligned sync restarts the frame
    beat_b(8'hA0, 1'b0);
    beat_b(8'hA1, 1'b0);
    beat_b(8'hB0, 1'b1);
    idle(1);
    chk("b_mis_err",  32'(err_b), 32'h1);
    chk("b_mis_dv",   32'(dv_b),  32'h0);
    chk("b_mis_sel",  32'(sel_b), 32'h1);
    chk("b_mis_dout", dout_b,     32'h44332211);
    beat_b(8'hB1, 1'b0);
    beat_b(8'hB2, 1'b0);
    beat_b(8'hB3, 1'b0);
    idle(1);
    chk("b_realign_dout", dout_b,    32'hB3B2B1B0);
    chk("b_realign_dv",   32'(dv_b), 32'h1);

    // B: reset mid-frame, then unsynced beats ignored
    beat_b(8'hC0, 1'b1);
    beat_b(8'hC1, 1'b0);
    do_reset();
    chk("b_midrst_dout", dout_b,      32'h0);
    chk("b_midrst_lock", 32'(lock_b), 32'h0);
    chk("b_midrst_sel",  32'(sel_b),  32'h0);
    beat_b(8'hD0, 1'b0);
    beat_b(8'hD1, 1'b0);
    beat_b(8'hD2, 1'b0);
    beat_b(8'hD3, 1'b0);
    idle(1);
    chk("b_ign_sel",  32'(sel_b),  32'h0);
    chk("b_ign_dout", dout_b,      32'h0);
    chk("b_ign_lock", 32'(lock_b), 32'h0);
    beat_b(8'hE0, 1'b1);
    beat_b(8'hE1, 1'b0);
    beat_b(8'hE2, 1'b0);
    beat_b(8'hE3, 1'b0);
    idle(1);
    chk("b_relock_dout", dout_b,    32'hE3E2E1E0);
    chk("b_relock_dv",   32'(dv_b), 32'h1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive-side counterpart of the 2:1 `mux` when that mux is used as a time-division serializer.
- Takes one time-multiplexed stream of WIDTH-bit beats, aligns to a frame-sync marker and steers each beat into its lane register.
- Presents a complete parallel frame of LANES words with a one-cycle valid pulse.
- Sits downstream of a slot-driven mux; `sel` mirrors the expected slot so benches can loop it back to the mux select.

Parameters:
- WIDTH, 1, bits per beat/lane.
- LANES, 2, slots per frame; legal range is 2 to 16.
- SW, $clog2(LANES), slot index width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- din  in  WIDTH  serialized beat
- din_valid  in  1  beat present this cycle
- sync  in  1  qualifies din as slot 0 of a frame; ignored when din_valid=0
- dout  out  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
- dout_valid  out  1  one-cycle pulse: dout updated with a new frame
- sel  out  SW  slot index the next accepted beat will fill
- locked  out  1  1 in RUN state
- sync_err  out  1  one-cycle pulse: sync seen mid-frame

Behaviour:
- Reset (rst=1 at a clk edge, including mid-frame):
  - dout=0, dout_valid=0, sel=0, locked=0, sync_err=0.
  - Shadow lane registers cleared; state=HUNT.
  - Any partial frame is discarded.
- Only cycles with din_valid=1 are beats. din_valid=0 holds all state; dout_valid and sync_err are 0 on such cycles.
- HUNT:
  - Beats without sync are dropped; sel stays 0.
  - A beat with sync writes shadow lane 0, sets sel=1 and moves to RUN; locked=1 from the next cycle.
- RUN, beat with sync=0:
  - Writes shadow lane sel.
  - If sel<LANES-1: sel increments.
  - If sel==LANES-1: at the same edge, dout takes the full shadow content including this beat, dout_valid=1 for exactly one cycle, and sel wraps to 0.
  - Latency from final accepted beat to dout_valid is 1 clk.
- RUN, beat with sync=1 and sel==0: normal frame start, no error.
- RUN, beat with sync=1 and sel!=0 (misalignment):
  - sync_err=1 for one cycle; the partial frame is discarded with no dout_valid.
  - The beat is written as lane 0, sel=1, and the block stays in RUN (re-aligned).
- RUN, beat at sel==0 with sync=0: accepted as lane 0. Sync is only required to acquire lock; it is optional afterwards.
- dout holds its value between frames. Shadow writes never disturb dout until frame completion.
- Priority: rst over everything, then the misaligned-sync rule, then the normal beat rule.
- sel is registered, never exceeds LANES-1, and wraps LANES-1→0 only on frame completion.
- locked drops only on rst. There is no loss-of-lock timeout.
- No backpressure: the block always accepts beats, so upstream never stalls.

Test Plan:
- Reset, then hold din_valid=0 for 5 clk → dout=0, sel=0, locked=0, dout_valid never 1.
- LANES=2, WIDTH=1:
  - Beats (din=0, sync=1) then (din=1, sync=0) → 1 clk after the 2nd beat: dout=2'b10, dout_valid=1 for one cycle, sel=0, locked=1.
  - In HUNT, beats din=1, 1, 0 all with sync=0 → all dropped, sel=0, no dout_valid. Then the sync beat din=1 followed by din=0 → dout=2'b01.
  - Locked: beat din=1 at sel=0 (no sync), 2 idle cycles, then beat din=1 → dout=2'b11 with a single dout_valid pulse; sel holds 1 during idle.
- LANES=4, WIDTH=8:
  - Frame 0x11, 0x22, 0x33, 0x44 → dout=0x44332211.
  - Next frame 0xA0, 0xA1, then sync beat 0xB0 → sync_err pulse, no dout_valid, sel=1. Continue 0xB1, 0xB2, 0xB3 → dout=0xB3B2B1B0.
- Assert rst for 1 clk after 2 beats of a frame → outputs back to reset values, locked=0. Subsequent beats without sync are ignored until the next sync.
